bcd_display_scanner: RTL and testbench
======================================

Name: bcd_display_scanner

Overview:
- Upstream driver for the seven_seg_controller BCD-to-segment decoder.
- Holds a 4-digit packed-BCD value and time-multiplexes it onto one shared decoder and a common-anode 4-digit display.
- Each refresh slot presents one digit's BCD nibble to the decoder while driving that digit's active-low anode and decimal point.
- Also does leading-zero blanking, anti-ghosting guard time between slots, and rejection of non-BCD loads.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot (1 kHz slot rate at 100 MHz). Must be >= GUARD+2.
- GUARD, 4: cycles at the start of each slot with all anodes off (anti-ghosting). 0 allowed.
- BLANK_LZ, 1: 1 enables leading-zero blanking; 0 shows all digits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  single-cycle strobe; capture value and dp_in.
- value  input  16  packed BCD: [15:12] digit3 (MSD) ... [3:0] digit0 (LSD).
- dp_in  input  4  decimal point request per digit, bit i = digit i.
- bcd  output  4  nibble of current digit; connects to the decoder's bcd input.
- an  output  4  anode enables, active-low, bit i = digit i.
- dp  output  1  decimal point segment, active-low.
- err  output  1  one-cycle pulse when a load is rejected.

Behaviour:
- Registers:
  - prescaler cnt, 0..REFRESH_DIV-1
  - digit index idx, 2 bits
  - shadow val_sh[15:0] and dp_sh[3:0]
  - err flop
- Reset (async, immediate, no clock edge needed): cnt=0, idx=0, val_sh=0, dp_sh=0, err=0.
  - Resulting outputs: bcd=0, dp=1, an=4'b1111 (guard window, since cnt<GUARD).
  - With GUARD=0, an=4'b1110 instead.
- Prescaler:
  - cnt increments every cycle.
  - When cnt==REFRESH_DIV-1, cnt wraps to 0 and idx increments, 3 wraps to 0.
  - Slot sequence: digit0, 1, 2, 3, 0, ...
  - Full scan period = 4*REFRESH_DIV cycles.
- Load:
  - On a clock edge with load=1 and every nibble of value <= 9: val_sh<=value, dp_sh<=dp_in.
  - Outputs reflect the new data from that edge on (0-cycle added latency; outputs are combinational from registers).
  - Load never disturbs cnt or idx.
  - If any nibble > 9: shadow unchanged, err=1 for exactly the next cycle.
  - Back-to-back invalid loads keep err high for each.
  - load=0: err=0 next cycle.
- Outputs (combinational from registers):
  - bcd = val_sh[4*idx+3 : 4*idx], always, even when the digit is blanked or in guard.
  - shown(i) is false when BLANK_LZ=1, i != 0, and for every digit j in i..3 both the nibble is 0 and dp_sh[j]=0; otherwise true. Digit0 is always shown.
  - an[idx]=0 only when cnt >= GUARD and shown(idx); all other an bits are 1.
  - At most one an bit is low at any time.
  - dp = 0 only when an[idx]=0 and dp_sh[idx]=1; else 1.
- Boundary conditions:
  - Load on the same edge as a slot change: the new idx and new shadow both apply after that edge.
  - Reset asserted mid-scan: all outputs go to reset values immediately.
  - After reset release, scanning restarts at digit0, cnt=0.

Test Plan (REFRESH_DIV=8, GUARD=2, BLANK_LZ=1 unless stated):
- Reset:
  - Stimulus: hold rst_n=0, then release.
  - Response while low: an=1111, bcd=0, dp=1, err=0.
  - After release: cycles 0-1 an=1111; cycles 2-7 an=1110, bcd=0; idx advances at cycle 8.
- Normal scan:
  - Stimulus: load value=16'h1234, dp_in=4'b0100.
  - Slot0: bcd=4, an=1110.
  - Slot1: bcd=3, an=1101.
  - Slot2: bcd=2, an=1011, dp=0.
  - Slot3: bcd=1, an=0111.
  - Then wraps to slot0; period 32 cycles; an=1111 and dp=1 in the first 2 cycles of each slot.
- Leading-zero blanking:
  - value=16'h0050: slots 3 and 2 an=1111 throughout; slot1 bcd=5, an=1101; slot0 bcd=0, an=1110.
  - value=0, dp_in=0: only slot0 lit, showing 0.
  - value=0, dp_in=4'b0100: digits 2, 1, 0 lit; digit2 dp=0; digit3 blank.
  - BLANK_LZ=0: all four lit.
- Invalid load:
  - After 1234 is displayed, load value=16'h12A4.
  - err=1 for exactly 1 cycle; display continues 1,2,3,4.
  - A following valid load of 16'h9999 is accepted, err=0.
- Reset mid-operation:
  - Assert rst_n=0 during slot2 at cnt=5, between clock edges.
  - an=1111, bcd=0, dp=1 immediately.
  - After release, the scan restarts at slot0 and the shadow reads 0.
- Load at slot boundary:
  - Pulse load=16'h5678 on the edge where cnt wraps 7->0.
  - The next slot shows the new data at the new idx; timing of the following slot change is unchanged (8 cycles later).

Source files
------------

// File: rtl/bcd_display_scanner_if.sv
// Shared bus between the scanner and whatever feeds it / consumes its outputs.
// The load side (load/value/dp_in) is driven by the master; the display side is driven by the scanner.
interface bcd_display_scanner_if;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        dp;
  logic        err;

  modport master (
    output load, value, dp_in,
    input  bcd, an, dp, err
  );

  modport slave (
    input  load, value, dp_in,
    output bcd, an, dp, err
  );
endinterface

// File: rtl/bcd_display_scanner.sv
// Time-multiplexes a 4-digit packed-BCD shadow register onto one shared BCD decoder
// and a common-anode display, with leading-zero blanking and an anti-ghosting guard window.
module bcd_display_scanner #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 4,
  parameter int BLANK_LZ    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_display_scanner_if.slave  bus
);

  localparam int              CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_val_sh;
  logic [3:0]       r_dp_sh;
  logic             r_err;

  logic             w_load_ok;
  logic             w_in_guard;
  logic [3:0]       w_shown;
  logic [3:0]       w_an;
  logic [3:0]       w_bcd;
  logic             w_dp;

  function automatic logic all_nibbles_bcd(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // A digit is blank only while it and every more-significant digit are zero with no dp.
  function automatic logic [3:0] shown_mask(input logic [15:0] v, input logic [3:0] d,
                                            input logic en);
    logic [3:0] m;
    logic       lead;
    lead = 1'b1;
    m    = 4'b1111;
    for (int i = 3; i >= 1; i--) begin
      lead = lead & (v[4*i +: 4] == 4'd0) & ~d[i];
      m[i] = ~(en & lead);
    end
    return m;
  endfunction

  assign w_load_ok = all_nibbles_bcd(bus.value);

  // Prescaler and digit index; loads never touch these.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Shadow capture and rejection flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val_sh <= 16'h0000;
      r_dp_sh  <= 4'b0000;
      r_err    <= 1'b0;
    end else begin
      r_err <= bus.load & ~w_load_ok;
      if (bus.load && w_load_ok) begin
        r_val_sh <= bus.value;
        r_dp_sh  <= bus.dp_in;
      end
    end
  end

  if (GUARD == 0) begin : g_noguard
    assign w_in_guard = 1'b0;
  end else begin : g_guard
    localparam logic [CNT_W-1:0] GUARD_C = CNT_W'(GUARD);
    assign w_in_guard = (r_cnt < GUARD_C);
  end

  assign w_shown = shown_mask(r_val_sh, r_dp_sh, (BLANK_LZ != 0));
  assign w_bcd   = r_val_sh[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_an = 4'b1111;
    if (!w_in_guard && w_shown[r_idx]) w_an[r_idx] = 1'b0;
  end

  assign w_dp = ~(~w_an[r_idx] & r_dp_sh[r_idx]);

  assign bus.bcd = w_bcd;
  assign bus.an  = w_an;
  assign bus.dp  = w_dp;
  assign bus.err = r_err;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner (REFRESH_DIV=8, GUARD=2) with side instances for
// BLANK_LZ=0 and GUARD=0 sharing the same stimulus.
module tb_bcd_display_scanner;

  logic clk;
  logic rst_n;

  bcd_display_scanner_if u_if ();
  bcd_display_scanner_if u_if_nlz ();
  bcd_display_scanner_if u_if_g0 ();

  bcd_display_scanner #(.REFRESH_DIV(8), .GUARD(2), .BLANK_LZ(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(u_if.slave)
  );
  bcd_display_scanner #(.REFRESH_DIV(8), .GUARD(2), .BLANK_LZ(0)) u_dut_nlz (
    .clk(clk), .rst_n(rst_n), .bus(u_if_nlz.slave)
  );
  bcd_display_scanner #(.REFRESH_DIV(8), .GUARD(0), .BLANK_LZ(1)) u_dut_g0 (
    .clk(clk), .rst_n(rst_n), .bus(u_if_g0.slave)
  );

  assign u_if_nlz.load  = u_if.load;
  assign u_if_nlz.value = u_if.value;
  assign u_if_nlz.dp_in = u_if.dp_in;
  assign u_if_g0.load   = u_if.load;
  assign u_if_g0.value  = u_if.value;
  assign u_if_g0.dp_in  = u_if.dp_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  int pos    = 0;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp_in;
    int          slot;
    int          c;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        dp;
  } vec_t;

  vec_t vecs[18];
  logic [15:0] cur_val;
  logic [3:0]  cur_dp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    pos++;
  endtask

  task automatic goto(input int slot, input int c);
    int n;
    n = 0;
    while ((pos % 32) != (slot * 8 + c) && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) begin
      ntests++;
      nfail++;
      $display("FAIL goto: position %0d never reached slot %0d cnt %0d", pos, slot, c);
    end
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    u_if.load  = 1'b1;
    u_if.value = v;
    u_if.dp_in = d;
    step();
    u_if.load  = 1'b0;
  endtask

  initial begin
    // value, dp_in, slot, cnt, bcd, an, dp
    vecs[0]  = '{16'h1234, 4'b0100, 0, 2, 4'h4, 4'b1110, 1'b1};
    vecs[1]  = '{16'h1234, 4'b0100, 0, 0, 4'h4, 4'b1111, 1'b1};
    vecs[2]  = '{16'h1234, 4'b0100, 1, 5, 4'h3, 4'b1101, 1'b1};
    vecs[3]  = '{16'h1234, 4'b0100, 2, 1, 4'h2, 4'b1111, 1'b1};
    vecs[4]  = '{16'h1234, 4'b0100, 2, 2, 4'h2, 4'b1011, 1'b0};
    vecs[5]  = '{16'h1234, 4'b0100, 3, 7, 4'h1, 4'b0111, 1'b1};
    vecs[6]  = '{16'h0050, 4'b0000, 3, 4, 4'h0, 4'b1111, 1'b1};
    vecs[7]  = '{16'h0050, 4'b0000, 2, 4, 4'h0, 4'b1111, 1'b1};
    vecs[8]  = '{16'h0050, 4'b0000, 1, 4, 4'h5, 4'b1101, 1'b1};
    vecs[9]  = '{16'h0050, 4'b0000, 0, 4, 4'h0, 4'b1110, 1'b1};
    vecs[10] = '{16'h0000, 4'b0000, 0, 3, 4'h0, 4'b1110, 1'b1};
    vecs[11] = '{16'h0000, 4'b0000, 1, 3, 4'h0, 4'b1111, 1'b1};
    vecs[12] = '{16'h0000, 4'b0000, 3, 3, 4'h0, 4'b1111, 1'b1};
    vecs[13] = '{16'h0000, 4'b0100, 3, 3, 4'h0, 4'b1111, 1'b1};
    vecs[14] = '{16'h0000, 4'b0100, 2, 3, 4'h0, 4'b1011, 1'b0};
    vecs[15] = '{16'h0000, 4'b0100, 1, 3, 4'h0, 4'b1101, 1'b1};
    vecs[16] = '{16'h0000, 4'b0100, 0, 3, 4'h0, 4'b1110, 1'b1};
    vecs[17] = '{16'h1000, 4'b0000, 2, 3, 4'h0, 4'b1011, 1'b1};

    u_if.load  = 1'b0;
    u_if.value = 16'h0000;
    u_if.dp_in = 4'b0000;
    rst_n      = 1'b1;
    #2 rst_n   = 1'b0;
    step();
    step();
    chk("rst_an", 32'(u_if.an), 32'(4'b1111));
    chk("rst_bcd", 32'(u_if.bcd), 32'h0);
    chk("rst_dp", 32'(u_if.dp), 32'h1);
    chk("rst_err", 32'(u_if.err), 32'h0);
    chk("rst_an_g0", 32'(u_if_g0.an), 32'(4'b1110));

    rst_n = 1'b1;
    pos   = 0;
    chk("rel_c0_an", 32'(u_if.an), 32'(4'b1111));
    step();
    chk("rel_c1_an", 32'(u_if.an), 32'(4'b1111));
    step();
    chk("rel_c2_an", 32'(u_if.an), 32'(4'b1110));
    chk("rel_c2_bcd", 32'(u_if.bcd), 32'h0);
    goto(0, 7);
    chk("rel_c7_an", 32'(u_if.an), 32'(4'b1110));
    goto(1, 2);
    chk("rel_s1_an", 32'(u_if.an), 32'(4'b1111));

    cur_val = 16'hFFFF;
    cur_dp  = 4'b1111;
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].value != cur_val || vecs[i].dp_in != cur_dp) begin
        do_load(vecs[i].value, vecs[i].dp_in);
        cur_val = vecs[i].value;
        cur_dp  = vecs[i].dp_in;
      end
      goto(vecs[i].slot, vecs[i].c);
      chk($sformatf("vec%0d_bcd", i), 32'(u_if.bcd), 32'(vecs[i].bcd));
      chk($sformatf("vec%0d_an", i), 32'(u_if.an), 32'(vecs[i].an));
      chk($sformatf("vec%0d_dp", i), 32'(u_if.dp), 32'(vecs[i].dp));
    end

    // Blanking disabled: every digit lights even for an all-zero value.
    do_load(16'h0000, 4'b0000);
    for (int s = 0; s < 4; s++) begin
      logic [3:0] exp_an;
      exp_an    = 4'b1111;
      exp_an[s] = 1'b0;
      goto(s, 3);
      chk($sformatf("nlz_s%0d_an", s), 32'(u_if_nlz.an), 32'(exp_an));
    end

    // Rejected load: shadow untouched, err exactly one cycle, back-to-back keeps it high.
    do_load(16'h1234, 4'b0000);
    chk("valid_err", 32'(u_if.err), 32'h0);
    do_load(16'h12A4, 4'b0000);
    chk("inv_err_hi", 32'(u_if.err), 32'h1);
    step();
    chk("inv_err_lo", 32'(u_if.err), 32'h0);
    goto(3, 4);
    chk("inv_s3_bcd", 32'(u_if.bcd), 32'h1);
    goto(2, 4);
    chk("inv_s2_bcd", 32'(u_if.bcd), 32'h2);
    goto(1, 4);
    chk("inv_s1_bcd", 32'(u_if.bcd), 32'h3);
    chk("inv_s1_an", 32'(u_if.an), 32'(4'b1101));
    goto(0, 4);
    chk("inv_s0_bcd", 32'(u_if.bcd), 32'h4);
    u_if.load  = 1'b1;
    u_if.value = 16'h12A4;
    step();
    chk("b2b_err1", 32'(u_if.err), 32'h1);
    u_if.value = 16'hF000;
    step();
    chk("b2b_err2", 32'(u_if.err), 32'h1);
    u_if.load = 1'b0;
    step();
    chk("b2b_err_lo", 32'(u_if.err), 32'h0);
    do_load(16'h9999, 4'b0000);
    chk("ok9999_err", 32'(u_if.err), 32'h0);
    chk("ok9999_bcd", 32'(u_if.bcd), 32'h9);

    // Asynchronous reset between clock edges during slot 2.
    do_load(16'h1234, 4'b0100);
    goto(2, 5);
    chk("pre_rst_an", 32'(u_if.an), 32'(4'b1011));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_an", 32'(u_if.an), 32'(4'b1111));
    chk("mid_rst_bcd", 32'(u_if.bcd), 32'h0);
    chk("mid_rst_dp", 32'(u_if.dp), 32'h1);
    step();
    step();
    rst_n = 1'b1;
    pos   = 0;
    goto(0, 2);
    chk("post_rst_an", 32'(u_if.an), 32'(4'b1110));
    chk("post_rst_bcd", 32'(u_if.bcd), 32'h0);
    goto(2, 2);
    chk("post_rst_s2_an", 32'(u_if.an), 32'(4'b1111));

    // Load on the wrap edge: new idx and new shadow both take effect together.
    do_load(16'h1234, 4'b0000);
    goto(0, 7);
    chk("bnd_pre_bcd", 32'(u_if.bcd), 32'h4);
    u_if.load  = 1'b1;
    u_if.value = 16'h5678;
    u_if.dp_in = 4'b0000;
    step();
    u_if.load = 1'b0;
    chk("bnd_c0_bcd", 32'(u_if.bcd), 32'h7);
    chk("bnd_c0_an", 32'(u_if.an), 32'(4'b1111));
    step();
    step();
    chk("bnd_c2_an", 32'(u_if.an), 32'(4'b1101));
    goto(1, 7);
    chk("bnd_c7_bcd", 32'(u_if.bcd), 32'h7);
    step();
    chk("bnd_next_bcd", 32'(u_if.bcd), 32'h6);
    chk("bnd_next_an", 32'(u_if.an), 32'(4'b1111));
    step();
    step();
    chk("bnd_next_an2", 32'(u_if.an), 32'(4'b1011));

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
